// File: rtl/clkgen_pkg.sv
// clkgen_pkg: shared types, constants and helpers for the clkgen_rst_seq slice.
package clkgen_pkg;

    // Reset sequencer states; encoding 3 is unused and recovers to SEQ_WAIT.
    typedef enum logic [1:0] {
        SEQ_WAIT  = 2'd0,
        SEQ_STAGE = 2'd1,
        SEQ_RUN   = 2'd2
    } seq_state_e;

    // Width and saturation value of the lock-loss event counter.
    localparam int              LLC_W   = 8;
    localparam logic [LLC_W-1:0] LLC_MAX = '1;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int bits_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Power-on divisor of channel i: 2^(i+1)-1, i.e. a period of 2^(i+1) cycles.
    function automatic logic [31:0] def_div(input int i);
        return (32'd1 << (i + 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/clkgen_div_ch.sv
// clkgen_div_ch: one clock-enable divider channel with a deferred runtime divisor.
// The divisor register only changes at a wrap, so a period in flight is never cut short.
// Optional square-wave output guarded by CLKGEN_SQUARE_EN.
module clkgen_div_ch
    import clkgen_pkg::*;
#(
    parameter int DIV_W  = 8,
    parameter int CH_IDX = 0
) (
    input  logic             clk_96M,
    input  logic             n_reset,
    input  logic             wr_en,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             ce_out
`ifdef CLKGEN_SQUARE_EN
    ,
    output logic             sq_out
`endif
);

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(def_div(CH_IDX));

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             ce_q, ce_d;
    logic             wrap;
`ifdef CLKGEN_SQUARE_EN
    logic             sq_q, sq_d;
`endif

    assign wrap = (cnt_q == div_q);

    // Next state: count up to the divisor, reload at the wrap, stage writes until then.
    always_comb begin
        // NOTE: every signal gets a default first so no branch can infer a latch.
        cnt_d      = wrap ? '0 : cnt_q + 1'b1;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        ce_d       = wrap;
        if (wrap) begin
            // A write landing on the wrap cycle takes effect at this very wrap.
            if (wr_en) begin
                div_d = cfg_div;
            end else if (pend_vld_q) begin
                div_d = pend_q;
            end
            pend_vld_d = 1'b0;
        end else if (wr_en) begin
            pend_d     = cfg_div;
            pend_vld_d = 1'b1;
        end
`ifdef CLKGEN_SQUARE_EN
        sq_d = sq_q ^ ce_q;
`endif
    end

    // Control and output flops with synchronous active-low reset.
    always_ff @(posedge clk_96M) begin
        // NOTE: non-blocking so every flop samples pre-edge values whatever the statement order.
        if (!n_reset) begin
            cnt_q      <= '0;
            div_q      <= DEF_DIV;
            pend_vld_q <= 1'b0;
            ce_q       <= 1'b0;
`ifdef CLKGEN_SQUARE_EN
            sq_q       <= 1'b0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_vld_q <= pend_vld_d;
            ce_q       <= ce_d;
`ifdef CLKGEN_SQUARE_EN
            sq_q       <= sq_d;
`endif
        end
    end

    // Pending divisor payload, qualified by pend_vld_q.
    always_ff @(posedge clk_96M) begin
        // NOTE: pure data storage carries no reset; clearing its valid flag discards it.
        pend_q <= pend_d;
    end

    assign ce_out = ce_q;
`ifdef CLKGEN_SQUARE_EN
    assign sq_out = sq_q;
`endif

endmodule

// File: rtl/clkgen_rst_seq.sv
// clkgen_rst_seq: clock-enable generator and staged reset sequencer for the 96 MHz core domain.
// N_CH divider channels run from reset; domain resets release in ascending order once
// the synchronised PLL lock has been stable for LOCK_FILT cycles, STAGGER cycles apart.
// Define CLKGEN_SQUARE_EN to add the clk_sq_out square-wave outputs.
module clkgen_rst_seq
    import clkgen_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int DIV_W     = 8,
    parameter int LOCK_FILT = 16,
    parameter int STAGGER   = 8
) (
    input  logic                      clk_96M,
    input  logic                      n_reset,
    input  logic                      pll_lock,
    input  logic                      cfg_we,
    input  logic [bits_for(N_CH)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]          cfg_div,
    output logic [N_CH-1:0]           ce_out,
    output logic [N_CH-1:0]           n_rst_dom,
    output logic                      all_ready,
    output logic [1:0]                seq_state,
    output logic [LLC_W-1:0]          lock_loss_cnt
`ifdef CLKGEN_SQUARE_EN
    ,
    output logic [N_CH-1:0]           clk_sq_out
`endif
);

    localparam int CH_W   = bits_for(N_CH);
    localparam int FILT_W = bits_for(LOCK_FILT);
    localparam int STG_W  = bits_for(STAGGER);

    logic [N_CH-1:0] wr_en;

    logic              lock_meta_q, lock_s_q;
    seq_state_e        state_q, state_d;
    logic [FILT_W-1:0] filt_q, filt_d;
    logic [STG_W-1:0]  stg_q, stg_d;
    logic [CH_W-1:0]   nxt_q, nxt_d;
    logic [N_CH-1:0]   dom_q, dom_d;
    logic              rdy_q, rdy_d;
    logic [LLC_W-1:0]  llc_q, llc_d;

    // Decode the divisor write; indices at or above N_CH match no channel and are dropped.
    always_comb begin
        wr_en = '0;
        for (int i = 0; i < N_CH; i++) begin
            wr_en[i] = cfg_we && (cfg_ch == CH_W'(i));
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        clkgen_div_ch #(
            .DIV_W  (DIV_W),
            .CH_IDX (gi)
        ) u_ch (
            .clk_96M (clk_96M),
            .n_reset (n_reset),
            .wr_en   (wr_en[gi]),
            .cfg_div (cfg_div),
            .ce_out  (ce_out[gi])
`ifdef CLKGEN_SQUARE_EN
            ,
            .sq_out  (clk_sq_out[gi])
`endif
        );
    end

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge clk_96M) begin
        if (!n_reset) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    // Sequencer next state: filter lock, release domains one stagger apart, drop all on loss.
    always_comb begin
        state_d = state_q;
        filt_d  = filt_q;
        stg_d   = stg_q;
        nxt_d   = nxt_q;
        dom_d   = dom_q;
        rdy_d   = rdy_q;
        llc_d   = llc_q;
        case (state_q)
            SEQ_WAIT: begin
                dom_d = '0;
                rdy_d = 1'b0;
                if (!lock_s_q) begin
                    filt_d = '0;
                end else if (filt_q == FILT_W'(LOCK_FILT - 1)) begin
                    filt_d   = '0;
                    stg_d    = '0;
                    nxt_d    = CH_W'(1);
                    dom_d[0] = 1'b1;
                    if (N_CH == 1) begin
                        state_d = SEQ_RUN;
                        rdy_d   = 1'b1;
                    end else begin
                        state_d = SEQ_STAGE;
                    end
                end else begin
                    filt_d = filt_q + 1'b1;
                end
            end
            SEQ_STAGE, SEQ_RUN: begin
                if (!lock_s_q) begin
                    state_d = SEQ_WAIT;
                    dom_d   = '0;
                    rdy_d   = 1'b0;
                    filt_d  = '0;
                    if (llc_q != LLC_MAX) begin
                        llc_d = llc_q + 1'b1;
                    end
                end else if (state_q == SEQ_STAGE) begin
                    if (stg_q == STG_W'(STAGGER - 1)) begin
                        stg_d        = '0;
                        dom_d[nxt_q] = 1'b1;
                        nxt_d        = nxt_q + 1'b1;
                        if (nxt_q == CH_W'(N_CH - 1)) begin
                            state_d = SEQ_RUN;
                            rdy_d   = 1'b1;
                        end
                    end else begin
                        stg_d = stg_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = SEQ_WAIT;
                dom_d   = '0;
                rdy_d   = 1'b0;
                filt_d  = '0;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk_96M) begin
        if (!n_reset) begin
            state_q <= SEQ_WAIT;
            filt_q  <= '0;
            stg_q   <= '0;
            nxt_q   <= '0;
            dom_q   <= '0;
            rdy_q   <= 1'b0;
            llc_q   <= '0;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            stg_q   <= stg_d;
            nxt_q   <= nxt_d;
            dom_q   <= dom_d;
            rdy_q   <= rdy_d;
            llc_q   <= llc_d;
        end
    end

    assign n_rst_dom     = dom_q;
    assign all_ready     = rdy_q;
    assign seq_state     = state_q;
    assign lock_loss_cnt = llc_q;

endmodule

// File: tb/tb_clkgen_rst_seq.sv
// tb_clkgen_rst_seq: directed scenarios plus randomized traffic against a reference model.
// The model predicts each cycle's outputs from wrap times and lock-run lengths;
// a negedge monitor pops the prediction and compares it with the DUT.
// A second, three-channel instance shares the stimulus so channel index 3 is out of range there.
module tb_clkgen_rst_seq;

    localparam int N  = 4;
    localparam int LF = 16;
    localparam int SG = 8;

    logic       clk_96M;
    logic       n_reset;
    logic       pll_lock;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;

    logic [3:0] ce_out, n_rst_dom;
    logic       all_ready;
    logic [1:0] seq_state;
    logic [7:0] lock_loss_cnt;

    logic [2:0] ce_out3, n_rst_dom3;
    logic       all_ready3;
    logic [1:0] seq_state3;
    logic [7:0] lock_loss_cnt3;
`ifdef CLKGEN_SQUARE_EN
    logic [3:0] clk_sq_out;
    logic [2:0] clk_sq_out3;
`endif

    clkgen_rst_seq #(.N_CH(4), .DIV_W(8), .LOCK_FILT(LF), .STAGGER(SG)) dut (
        .clk_96M       (clk_96M),
        .n_reset       (n_reset),
        .pll_lock      (pll_lock),
        .cfg_we        (cfg_we),
        .cfg_ch        (cfg_ch),
        .cfg_div       (cfg_div),
        .ce_out        (ce_out),
        .n_rst_dom     (n_rst_dom),
        .all_ready     (all_ready),
        .seq_state     (seq_state),
        .lock_loss_cnt (lock_loss_cnt)
`ifdef CLKGEN_SQUARE_EN
        ,
        .clk_sq_out    (clk_sq_out)
`endif
    );

    clkgen_rst_seq #(.N_CH(3), .DIV_W(8), .LOCK_FILT(LF), .STAGGER(SG)) dut3 (
        .clk_96M       (clk_96M),
        .n_reset       (n_reset),
        .pll_lock      (pll_lock),
        .cfg_we        (cfg_we),
        .cfg_ch        (cfg_ch),
        .cfg_div       (cfg_div),
        .ce_out        (ce_out3),
        .n_rst_dom     (n_rst_dom3),
        .all_ready     (all_ready3),
        .seq_state     (seq_state3),
        .lock_loss_cnt (lock_loss_cnt3)
`ifdef CLKGEN_SQUARE_EN
        ,
        .clk_sq_out    (clk_sq_out3)
`endif
    );

    initial clk_96M = 1'b0;
    always #5 clk_96M = ~clk_96M;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_96M);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [3:0] ce;
        logic [3:0] dom;
        logic       rdy;
        logic [1:0] st;
        logic [7:0] llc;
        logic [3:0] sq;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned mt = 0;
    int unsigned m_div[N], m_pend[N], m_next[N];
    bit          m_pv[N];
    bit          m_rel;
    int unsigned m_base, m_run, m_loss;
    bit          m_pipe[$];
    logic [3:0]  m_ce = '0, m_sq = '0;

    always @(posedge clk_96M) begin : model
        exp_t       e;
        logic [3:0] prev_ce;
        bit         seen, wrap, wr;
        prev_ce = m_ce;
        mt++;
        if (!n_reset) begin
            for (int i = 0; i < N; i++) begin
                m_div[i]  = (1 << (i + 1)) - 1;
                m_pv[i]   = 1'b0;
                m_next[i] = mt + m_div[i] + 1;
            end
            m_ce   = '0;
            m_sq   = '0;
            m_rel  = 1'b0;
            m_run  = 0;
            m_loss = 0;
            m_pipe.delete();
            m_pipe.push_back(1'b0);
            m_pipe.push_back(1'b0);
        end else begin
            for (int i = 0; i < N; i++) begin
                wrap = (mt == m_next[i]);
                wr   = cfg_we && (int'(cfg_ch) == i);
                if (wrap) begin
                    if (wr)          m_div[i] = cfg_div;
                    else if (m_pv[i]) m_div[i] = m_pend[i];
                    m_pv[i]   = 1'b0;
                    m_next[i] = mt + m_div[i] + 1;
                end else if (wr) begin
                    m_pend[i] = cfg_div;
                    m_pv[i]   = 1'b1;
                end
                m_ce[i] = wrap;
            end
            m_sq = m_sq ^ prev_ce;
            seen = m_pipe.pop_front();
            m_pipe.push_back(pll_lock);
            if (m_rel) begin
                if (!seen) begin
                    m_rel  = 1'b0;
                    m_run  = 0;
                    m_loss = (m_loss < 255) ? m_loss + 1 : 255;
                end
            end else if (seen) begin
                m_run++;
                if (m_run == LF) begin
                    m_rel  = 1'b1;
                    m_base = mt;
                end
            end else begin
                m_run = 0;
            end
        end
        e.ce = m_ce;
        for (int k = 0; k < N; k++) e.dom[k] = m_rel && (mt - m_base >= SG * k);
        e.rdy = m_rel && (mt - m_base >= SG * (N - 1));
        e.st  = !m_rel ? 2'd0 : (e.rdy ? 2'd2 : 2'd1);
        e.llc = 8'(m_loss);
        e.sq  = m_sq;
        exp_q.push_back(e);
    end

    // ---------------- monitor ----------------
    always @(negedge clk_96M) begin : monitor
        exp_t e, a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a.ce  = ce_out;
            a.dom = n_rst_dom;
            a.rdy = all_ready;
            a.st  = seq_state;
            a.llc = lock_loss_cnt;
`ifdef CLKGEN_SQUARE_EN
            a.sq  = clk_sq_out;
`else
            a.sq  = '0;
            e.sq  = '0;
`endif
            n_checks++;
            if (a !== e) begin
                n_err++;
                $display("FAIL scoreboard @%0t: got ce=%b dom=%b rdy=%b st=%0d llc=%0d sq=%b, want ce=%b dom=%b rdy=%b st=%0d llc=%0d sq=%b",
                         $time, a.ce, a.dom, a.rdy, a.st, a.llc, a.sq, e.ce, e.dom, e.rdy, e.st, e.llc, e.sq);
            end
            n_checks++;
            if ({ce_out3, n_rst_dom3} !== {e.ce[2:0], e.dom[2:0]}) begin
                n_err++;
                $display("FAIL scoreboard_3ch @%0t: got ce=%b dom=%b, want ce=%b dom=%b",
                         $time, ce_out3, n_rst_dom3, e.ce[2:0], e.dom[2:0]);
            end
        end
    end

    task automatic do_reset(input int n);
        n_reset = 1'b0;
        cfg_we  = 1'b0;
        repeat (n) step();
        n_reset = 1'b1;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [7:0] dv);
        cfg_we  = 1'b1;
        cfg_ch  = ch;
        cfg_div = dv;
        step();
        cfg_we  = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int first_ce3, r0, r1, r3, rr;
        n_reset  = 1'b0;
        pll_lock = 1'b1;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_div  = '0;

        // Defaults and a clean staged release with lock held from reset release.
        repeat (3) step();
        check("reset_dom", int'(n_rst_dom), 0);
        check("reset_ce", int'(ce_out), 0);
        n_reset = 1'b1;
        first_ce3 = -1; r0 = -1; r1 = -1; r3 = -1; rr = -1;
        for (int e = 1; e <= 50; e++) begin
            step();
            if (ce_out[3] && first_ce3 < 0) first_ce3 = e;
            if (n_rst_dom[0] && r0 < 0) r0 = e;
            if (n_rst_dom[1] && r1 < 0) r1 = e;
            if (n_rst_dom[3] && r3 < 0) r3 = e;
            if (all_ready && rr < 0) rr = e;
            if (e == 17) check("state_wait_pre_release", int'(seq_state), 0);
            if (e == 20) check("state_stage", int'(seq_state), 1);
        end
        check("first_ce3_edge", first_ce3, 16);
        check("dom0_release_edge", r0, 18);
        check("dom1_release_edge", r1, 26);
        check("dom3_release_edge", r3, 42);
        check("all_ready_edge", rr, 42);
        check("state_run", int'(seq_state), 2);

        // Lock glitch part-way through the filter restarts it.
        do_reset(2);
        repeat (12) step();
        pll_lock = 1'b0;
        repeat (3) step();
        pll_lock = 1'b1;
        r0 = -1;
        for (int e = 16; e <= 40; e++) begin
            step();
            if (n_rst_dom[0] && r0 < 0) r0 = e;
        end
        check("glitch_dom0_edge", r0, 33);

        // Lock loss in RUN, then re-lock.
        rr = -1;
        for (int e = 0; e < 100 && rr < 0; e++) begin
            step();
            if (all_ready) rr = e;
        end
        check("reach_run", int'(rr >= 0), 1);
        pll_lock = 1'b0;
        r0 = -1;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (n_rst_dom == 4'b0 && r0 < 0) r0 = e;
        end
        check("loss_clear_edge", r0, 3);
        check("loss_all_ready", int'(all_ready), 0);
        check("loss_count_1", int'(lock_loss_cnt), 1);
        pll_lock = 1'b1;
        r0 = -1;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (n_rst_dom[0] && r0 < 0) r0 = e;
        end
        check("relock_dom0_edge", r0, 18);

        // Saturation of the lock-loss counter.
        for (int i = 1; i <= 300; i++) begin
            pll_lock = 1'b1;
            repeat (20) step();
            pll_lock = 1'b0;
            repeat (4) step();
            if (i == 200) check("loss_count_201", int'(lock_loss_cnt), 201);
        end
        check("loss_count_sat", int'(lock_loss_cnt), 255);

        // Runtime divisor writes with domains held in reset.
        pll_lock = 1'b0;
        do_reset(2);
        repeat (10) step();
        wr(2'd2, 8'd2);
        wr(2'd3, 8'd0);
        wr(2'd1, 8'd0);
        for (int e = 14; e <= 25; e++) begin
            step();
            check($sformatf("ch2_strobe_e%0d", e), int'(ce_out[2]),
                  int'(e == 16 || e == 19 || e == 22 || e == 25));
            if (e >= 17) check($sformatf("ch1_const_e%0d", e), int'(ce_out[1]), 1);
        end

        // Reset asserted during STAGE.
        pll_lock = 1'b1;
        do_reset(2);
        rr = -1;
        for (int e = 0; e < 40 && rr < 0; e++) begin
            step();
            if (seq_state == 2'd1) rr = e;
        end
        check("reach_stage", int'(rr >= 0), 1);
        repeat (3) step();
        n_reset = 1'b0;
        step();
        check("stage_reset_dom", int'(n_rst_dom), 0);
        check("stage_reset_state", int'(seq_state), 0);
        check("stage_reset_ready", int'(all_ready), 0);
        check("stage_reset_ce", int'(ce_out), 0);
`ifdef CLKGEN_SQUARE_EN
        check("stage_reset_sq", int'(clk_sq_out), 0);
`endif
        n_reset = 1'b1;

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            cfg_we  = ($urandom_range(0, 5) == 0);
            cfg_ch  = 2'($urandom_range(0, 3));
            cfg_div = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
            if ($urandom_range(0, 29) == 0) pll_lock = ~pll_lock;
            n_reset = ($urandom_range(0, 699) != 0);
            step();
        end
        cfg_we  = 1'b0;
        n_reset = 1'b1;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
